cic_comp_fir: RTL and testbench

- Serial-MAC compensation FIR placed directly after the 8-stage CIC decimator (cic_decim_8_12_20).
- Consumes the CIC's 20-bit output and its cken_out strobe. Corrects the CIC passband droop and produces a 20-bit rounded, saturated result with its own one-cycle strobe.
- Uses one multiplier, time-multiplexed over NTAPS clocks per input sample.

---
 rtl/cic_comp_fir.sv | 205 ++++++++++++++++++++
 tb/tb_cic_comp_fir.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: serial-MAC compensation FIR that follows the CIC decimator.
// A single multiplier is swept over NTAPS taps for each input sample.
// The result is rounded half-up from Q1.17 and saturated to 20 bits.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   cken_in    one-cycle input sample strobe (CIC cken_out)
//   din        signed 20-bit input sample, valid with cken_in
//   dout       signed 20-bit filtered output, held between strobes
//   cken_out   one-cycle pulse when dout updates
//   busy       high while a sweep is in progress
//   overrun    sticky: a sample arrived while busy (cleared by reset only)
//
// Optional macro CIC_COMP_COEF_LOAD_EN:
//   defined   -> adds coef_we / coef_addr / coef_data; coefficients live in
//                registers that reset to zero and are writable only when idle
//   undefined -> constant compensation set (mirrors cic_comp_coefs.vh)
module cic_comp_fir #(
  parameter int unsigned NTAPS = 16,
  parameter int unsigned CW    = 18,
  parameter int unsigned AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cken_in,
  input  logic signed [19:0]   din,
`ifdef CIC_COMP_COEF_LOAD_EN
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
`endif
  output logic signed [19:0]   dout,
  output logic                 cken_out,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned DW   = 20;
  localparam int unsigned TW   = $clog2(NTAPS);
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned ACW  = PW + AW;
  localparam int unsigned FRAC = CW - 1;
  localparam int unsigned RW   = ACW - FRAC;

  localparam logic signed [ACW-1:0] RND_HALF = ACW'(1 << (FRAC - 1));
  localparam logic signed [RW-1:0]  SAT_HI   = RW'((1 << (DW - 1)) - 1);
  localparam logic signed [RW-1:0]  SAT_LO   = RW'(-(1 << (DW - 1)));

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

  state_t                 state, state_nx;
  logic                   accept_c, mac_c, drop_c;
  logic [TW-1:0]          wptr, base, tap, rd_idx_c;
  logic signed [DW-1:0]   sbuf [NTAPS];
  logic signed [DW-1:0]   x_c;
  logic signed [CW-1:0]   coef_c;
  logic signed [PW-1:0]   prod;
  logic                   prod_vld, prod_first;
  logic signed [ACW-1:0]  acc, acc_rnd_c;
  logic signed [RW-1:0]   acc_q_c;
  logic signed [DW-1:0]   sat_c;

`ifdef CIC_COMP_COEF_LOAD_EN
  logic signed [CW-1:0] coef_q [NTAPS];

  // Coefficient registers; writes only land while idle and in range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_q <= '{default: '0};
    end else if (coef_we && state == IDLE && 32'(coef_addr) < NTAPS) begin
      coef_q[coef_addr[TW-1:0]] <= coef_data;
    end
  end

  assign coef_c = coef_q[tap];
`else
  // Symmetric droop-compensation set, Q1.17, unity DC gain
  function automatic logic signed [CW-1:0] coef_rom(input int unsigned k);
    logic signed [CW-1:0] c;
    case (k)
      0, 15:   c = CW'(-300);
      1, 14:   c = CW'(800);
      2, 13:   c = CW'(-1600);
      3, 12:   c = CW'(2500);
      4, 11:   c = CW'(-3200);
      5, 10:   c = CW'(2000);
      6, 9:    c = CW'(9000);
      7, 8:    c = CW'(56336);
      default: c = '0;
    endcase
    return c;
  endfunction

  assign coef_c = coef_rom(32'(tap));
`endif

  // Newest sample pairs with coef[0]; index wraps naturally (NTAPS = 2**TW)
  assign rd_idx_c = base - tap;
  assign x_c      = sbuf[rd_idx_c];

  // Round half-up out of Q1.17, then clamp to the 20-bit range
  assign acc_rnd_c = acc + RND_HALF;
  assign acc_q_c   = RW'(acc_rnd_c >>> FRAC);

  always_comb begin
    sat_c = DW'(acc_q_c);
    if (acc_q_c > SAT_HI) begin
      sat_c = DW'(SAT_HI);
    end else if (acc_q_c < SAT_LO) begin
      sat_c = DW'(SAT_LO);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle controls
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    mac_c    = 1'b0;
    drop_c   = 1'b0;
    case (state)
      IDLE: begin
        if (cken_in) begin
          accept_c = 1'b1;
          state_nx = MAC;
        end
      end
      MAC: begin
        mac_c  = 1'b1;
        drop_c = cken_in;
        if (tap == TW'(NTAPS - 1)) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        drop_c   = cken_in;
        state_nx = OUT;
      end
      OUT: begin
        drop_c   = cken_in;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sample buffer, MAC pipeline and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbuf       <= '{default: '0};
      wptr       <= '0;
      base       <= '0;
      tap        <= '0;
      prod       <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      acc        <= '0;
      dout       <= '0;
      cken_out   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      prod_vld   <= mac_c;
      prod_first <= mac_c && (tap == '0);
      cken_out   <= (state == OUT);
      busy       <= (state_nx != IDLE);

      if (accept_c) begin
        sbuf[wptr] <= din;
        base       <= wptr;
        wptr       <= wptr + TW'(1);
        tap        <= '0;
      end else if (mac_c) begin
        tap <= tap + TW'(1);
      end

      if (mac_c) begin
        prod <= PW'(x_c) * PW'(coef_c);
      end

      // First product of a sweep replaces the previous sweep's total
      if (prod_vld) begin
        acc <= prod_first ? ACW'(prod) : acc + ACW'(prod);
      end

      if (state == OUT) begin
        dout <= sat_c;
      end

      if (drop_c) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: a reference model computes each
// expected output when a sample is accepted and queues it with its due cycle;
// the monitor pops and compares whenever cken_out fires.
module tb_cic_comp_fir;

  localparam int NT = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               cken_in;
  logic signed [19:0] din;
  logic signed [19:0] dout;
  logic               cken_out;
  logic               busy;
  logic               overrun;
`ifdef CIC_COMP_COEF_LOAD_EN
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [17:0] coef_data;
`endif

  cic_comp_fir dut (
    .clk       (clk),
    .reset     (reset),
    .cken_in   (cken_in),
    .din       (din),
`ifdef CIC_COMP_COEF_LOAD_EN
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
`endif
    .dout      (dout),
    .cken_out  (cken_out),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    longint due;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_x;
  int     mcoef [NT];
  int     mbuf  [NT];
  int     mwptr;
  longint next_ok;
  longint last_acc;
  longint last_exp;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbuf     = '{default: 0};
    mwptr    = 0;
    next_ok  = 0;
    last_acc = -100;
    last_exp = 0;
    sb.delete();
`ifdef CIC_COMP_COEF_LOAD_EN
    mcoef = '{default: 0};
`else
    mcoef = '{-300, 800, -1600, 2500, -3200, 2000, 9000, 56336,
              56336, 9000, 2000, -3200, 2500, -1600, 800, -300};
`endif
  endtask

  function automatic longint model_out(input int b);
    longint acc = 0;
    longint r;
    for (int k = 0; k < NT; k++) begin
      acc += longint'(mbuf[4'(b - k)]) * longint'(mcoef[4'(k)]);
    end
    r = (acc + 65536) >>> 17;
    if (r > 524287)  r = 524287;
    if (r < -524288) r = -524288;
    return r;
  endfunction

  // Called at a negedge; the sample is taken at the following posedge
  task automatic send(input int val);
    longint e = cyc + 1;
    exp_t   x;
    cken_in = 1'b1;
    din     = 20'(val);
    @(negedge clk);
    cken_in = 1'b0;
    if (e >= next_ok) begin
      mbuf[4'(mwptr)] = val;
      x.val = model_out(mwptr);
      x.due = e + 18;
      sb.push_back(x);
      mwptr    = (mwptr + 1) % NT;
      next_ok  = e + 19;
      last_acc = e;
      check("busy_after_accept", busy, 1);
    end else begin
      check("overrun_set", overrun, 1);
    end
  endtask

`ifdef CIC_COMP_COEF_LOAD_EN
  task automatic load_coef(input int addr, input int val);
    longint e = cyc + 1;
    coef_we   = 1'b1;
    coef_addr = 5'(addr);
    coef_data = 18'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < NT && !(e > last_acc && e < last_acc + 19)) mcoef[4'(addr)] = val;
  endtask
`endif

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_dout", dout, 0);
    check("rst_cken_out", cken_out, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && cken_out) begin
      if (sb.size() == 0) begin
        check("spurious_cken", cken_out, 0);
      end else begin
        mon_x = sb.pop_front();
        last_exp = mon_x.val;
        check("cken_time", cyc, mon_x.due);
        check("dout", dout, mon_x.val);
        check("busy_at_out", busy, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset   = 1'b1;
    cken_in = 1'b0;
    din     = '0;
`ifdef CIC_COMP_COEF_LOAD_EN
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check("init_dout", dout, 0);
    check("init_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Impulse and hold
`ifdef CIC_COMP_COEF_LOAD_EN
    load_coef(0, 65536);
`endif
    send(1000);
    wait_idle();
`ifdef CIC_COMP_COEF_LOAD_EN
    check("imp_dout", dout, 500);
`endif
    repeat (20) @(negedge clk);
    check("imp_hold", dout, last_exp);

`ifdef CIC_COMP_COEF_LOAD_EN
    // Coefficient writes while busy or out of range are dropped
    send(1000);
    repeat (3) @(negedge clk);
    load_coef(0, 0);
    wait_idle();
    load_coef(16, 12345);
    send(2000);
    wait_idle();
    check("coef_guard", dout, 1000);
`endif

    // Moving average: 16 equal taps ramp up, then hold full scale
    do_reset();
`ifdef CIC_COMP_COEF_LOAD_EN
    for (int i = 0; i < NT; i++) load_coef(i, 8192);
`endif
    for (int i = 0; i < 17; i++) begin
      send(4096);
      repeat (19) @(negedge clk);
`ifdef CIC_COMP_COEF_LOAD_EN
      check("avg_step", dout, (i < 16 ? i + 1 : 16) * 256);
`else
      check("avg_step", dout, last_exp);
`endif
    end

    // Saturation at both rails
    do_reset();
`ifdef CIC_COMP_COEF_LOAD_EN
    load_coef(0, 131071);
    load_coef(1, 131071);
`endif
    send(524287);
    repeat (19) @(negedge clk);
    send(524287);
    wait_idle();
`ifdef CIC_COMP_COEF_LOAD_EN
    check("sat_pos", dout, 524287);
`endif
    send(-524288);
    repeat (19) @(negedge clk);
    send(-524288);
    wait_idle();
`ifdef CIC_COMP_COEF_LOAD_EN
    check("sat_neg", dout, -524288);
`endif

    // Overrun: sample 5 cycles in is dropped; sample in cken_out cycle is kept
    do_reset();
`ifdef CIC_COMP_COEF_LOAD_EN
    load_coef(0, 65536);
    load_coef(1, 65536);
`endif
    send(1000);
    repeat (4) @(negedge clk);
    send(3000);
    n = 0;
    while (!cken_out && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ovr_wait_cken", cken_out, 1);
`ifdef CIC_COMP_COEF_LOAD_EN
    check("ovr_first", dout, 500);
`endif
    send(2000);
    check("ovr_sticky", overrun, 1);
    wait_idle();
`ifdef CIC_COMP_COEF_LOAD_EN
    check("ovr_second", dout, 1500);
`endif

    // Reset mid-sweep: no output, no residue from the aborted data
    do_reset();
`ifdef CIC_COMP_COEF_LOAD_EN
    load_coef(0, 65536);
    load_coef(1, 65536);
`endif
    send(777);
    repeat (7) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    check("no_cken_after_rst", sb.size(), 0);
`ifdef CIC_COMP_COEF_LOAD_EN
    load_coef(0, 65536);
    load_coef(1, 65536);
`endif
    send(1000);
    wait_idle();
`ifdef CIC_COMP_COEF_LOAD_EN
    check("post_rst", dout, 500);
`endif
    check("final_overrun", overrun, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
